// File: rtl/fifo_serializer.sv
// fifo_serializer: drains words from an upstream FIFO (pndng/pop handshake)
// and sends each one as an asynchronous serial frame: start bit, data LSB
// first, optional parity bit, stop bit. Frames run back-to-back with no idle
// gap while the FIFO holds data. Every output comes straight from a flop.
module fifo_serializer #(
  parameter int unsigned bits         = 8,
  parameter int unsigned clks_per_bit = 16,
  parameter bit          parity_en    = 1'b0,
  parameter bit          parity_odd   = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            pndng,
  input  logic [bits-1:0] Din,
  output logic            pop,
  output logic            tx,
  output logic            busy,
  output logic            done
);

  localparam int unsigned BAUD_W = $clog2(clks_per_bit);
  localparam int unsigned IDX_W  = $clog2(bits + 1);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(clks_per_bit - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(bits - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t            state_q, state_d;
  logic [BAUD_W-1:0] baud_q,  baud_d;
  logic [IDX_W-1:0]  idx_q,   idx_d;
  logic [bits-1:0]   shift_q, shift_d;
  logic              par_q,   par_d;
  logic              pop_q,   pop_d;
  logic              tx_q,    tx_d;
  logic              busy_q,  busy_d;
  logic              done_q,  done_d;

  logic baud_last;
  logic take;

  // End of the current serial bit, and the edge on which a new word is captured.
  assign baud_last = (baud_q == BAUD_LAST);
  assign take      = pndng && ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_last));

  // Next-state logic: frame sequencing, bit shifting and registered output values.
  always_comb begin
    // NOTE: every signal gets a default before the case so that no path
    // leaves it unassigned; otherwise synthesis infers a latch.
    state_d = state_q;
    baud_d  = baud_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop_d   = 1'b0;
    done_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        baud_d = '0;
      end
      S_START: begin
        if (baud_last) begin
          state_d = S_DATA;
          idx_d   = '0;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_DATA: begin
        if (baud_last) begin
          shift_d = shift_q >> 1;
          idx_d   = idx_q + IDX_W'(1);
          baud_d  = '0;
          if (idx_q == IDX_LAST) begin
            state_d = parity_en ? S_PARITY : S_STOP;
          end
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_PARITY: begin
        if (baud_last) begin
          state_d = S_STOP;
          baud_d  = '0;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      S_STOP: begin
        if (baud_last) begin
          done_d  = 1'b1;
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + BAUD_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase

    // Capture overrides the IDLE hold and the STOP->IDLE return, so the next
    // START bit directly follows the last stop cycle.
    if (take) begin
      shift_d = Din;
      par_d   = (^Din) ^ parity_odd;
      pop_d   = 1'b1;
      state_d = S_START;
      baud_d  = '0;
    end

    // Line level and busy are derived from the next state so they are
    // registered yet line up with the state they describe.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[0];
      S_PARITY: tx_d = par_d;
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops
    // update together on the edge regardless of statement order.
    if (!rst) begin
      state_q <= S_IDLE;
      baud_q  <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      pop_q   <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      pop_q   <= pop_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pop  = pop_q;
  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_fifo_serializer.sv
// Bench for fifo_serializer: three instances (no parity, even, odd) at
// 8 data bits and 4 clocks per bit, driven by a table of single-word frames
// plus hand-written reset, back-to-back and mid-frame reset sequences.
module tb_fifo_serializer;

  localparam int CPB = 4;

  logic clk;
  logic rst;

  logic       pndng_p, pndng_e, pndng_o;
  logic [7:0] din_p,   din_e,   din_o;
  logic       pop_p,   pop_e,   pop_o;
  logic       tx_p,    tx_e,    tx_o;
  logic       busy_p,  busy_e,  busy_o;
  logic       done_p,  done_e,  done_o;

  int n_checks = 0;
  int n_pass   = 0;

  fifo_serializer #(.bits(8), .clks_per_bit(CPB), .parity_en(1'b0), .parity_odd(1'b0)) u_plain (
    .clk(clk), .rst(rst), .pndng(pndng_p), .Din(din_p),
    .pop(pop_p), .tx(tx_p), .busy(busy_p), .done(done_p)
  );

  fifo_serializer #(.bits(8), .clks_per_bit(CPB), .parity_en(1'b1), .parity_odd(1'b0)) u_even (
    .clk(clk), .rst(rst), .pndng(pndng_e), .Din(din_e),
    .pop(pop_e), .tx(tx_e), .busy(busy_e), .done(done_e)
  );

  fifo_serializer #(.bits(8), .clks_per_bit(CPB), .parity_en(1'b1), .parity_odd(1'b1)) u_odd (
    .clk(clk), .rst(rst), .pndng(pndng_o), .Din(din_o),
    .pop(pop_o), .tx(tx_o), .busy(busy_o), .done(done_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // {tx, busy, pop, done} of the selected instance.
  function automatic logic [3:0] outs(input int inst);
    case (inst)
      0:       return {tx_p, busy_p, pop_p, done_p};
      1:       return {tx_e, busy_e, pop_e, done_e};
      default: return {tx_o, busy_o, pop_o, done_o};
    endcase
  endfunction

  task automatic drive_in(input int inst, input logic p, input logic [7:0] d);
    case (inst)
      0:       begin pndng_p = p; din_p = d; end
      1:       begin pndng_e = p; din_e = d; end
      default: begin pndng_o = p; din_o = d; end
    endcase
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One word offered for a single sample; checks the whole frame and the
  // cycle after it. Cycle 1 is the first START cycle.
  task automatic run_frame(input int inst, input logic [7:0] d, input string seq, input string name);
    int         nb;
    int         f;
    int         pops;
    int         pop_at;
    int         bad_bit;
    logic       busy_ok;
    logic       done_early;
    logic [3:0] o;
    nb         = seq.len();
    f          = nb * CPB;
    pops       = 0;
    pop_at     = -1;
    bad_bit    = -1;
    busy_ok    = 1'b1;
    done_early = 1'b0;
    drive_in(inst, 1'b1, d);
    step();
    // Din is not required to hold after the take edge.
    drive_in(inst, 1'b0, d ^ 8'h5A);
    for (int c = 1; c <= f; c++) begin
      if (c > 1) step();
      o = outs(inst);
      if ((o[3] !== (seq[(c-1)/CPB] == "1")) && (bad_bit < 0)) bad_bit = (c - 1) / CPB;
      if (o[2] !== 1'b1) busy_ok = 1'b0;
      if (o[1] === 1'b1) begin
        pops++;
        if (pop_at < 0) pop_at = c;
      end
      if (o[0] !== 1'b0) done_early = 1'b1;
    end
    check({name, "/tx_first_bad_bit"}, bad_bit, -1);
    check({name, "/pop_count"}, pops, 1);
    check({name, "/pop_cycle"}, pop_at, 1);
    check({name, "/busy_during_frame"}, {31'd0, busy_ok}, 1);
    check({name, "/done_early"}, {31'd0, done_early}, 0);
    step();
    o = outs(inst);
    check({name, "/after_frame_tx_busy_pop_done"}, {28'd0, o}, 4'b1001);
  endtask

  typedef struct {
    int         inst;
    logic [7:0] din;
    string      seq;
    string      name;
  } frame_vec_t;

  frame_vec_t vecs[6];

  initial begin
    logic [3:0] o;
    string      b2b_seq;
    int         pop_at[3];
    int         done_at[3];
    int         n_pop;
    int         n_done;
    int         bad_cyc;
    logic       busy_ok;
    logic [7:0] fifo_q[$];

    // Expected line levels, one character per bit: start, d0..d7, [parity], stop.
    vecs[0] = '{0, 8'hA5, "0101001011",  "plain_a5"};
    vecs[1] = '{0, 8'h3C, "0001111001",  "plain_3c"};
    vecs[2] = '{1, 8'h07, "01110000011", "even_07"};
    vecs[3] = '{2, 8'h07, "01110000001", "odd_07"};
    vecs[4] = '{1, 8'h00, "00000000001", "even_00"};
    vecs[5] = '{2, 8'h00, "00000000011", "odd_00"};

    // Reset held with a word pending: no frame may start.
    rst = 1'b0;
    drive_in(0, 1'b1, 8'hA5);
    drive_in(1, 1'b0, 8'h00);
    drive_in(2, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step();
      o = outs(0);
      check($sformatf("reset_cycle%0d_tx_busy_pop_done", i), {28'd0, o}, 4'b1000);
    end
    rst = 1'b1;
    drive_in(0, 1'b0, 8'h00);
    step();
    step();
    o = outs(0);
    check("idle_after_reset", {28'd0, o}, 4'b1000);

    // Table-driven single frames.
    for (int i = 0; i < 6; i++) begin
      run_frame(vecs[i].inst, vecs[i].din, vecs[i].seq, vecs[i].name);
      step();
    end

    // Back-to-back: FIFO model preloaded with three words.
    fifo_q  = '{8'h01, 8'h80, 8'hFF};
    b2b_seq = {"0100000001", "0000000011", "0111111111"};
    for (int i = 0; i < 3; i++) begin
      pop_at[i]  = -1;
      done_at[i] = -1;
    end
    n_pop   = 0;
    n_done  = 0;
    bad_cyc = -1;
    busy_ok = 1'b1;
    drive_in(0, 1'b1, fifo_q[0]);
    for (int c = 1; c <= 121; c++) begin
      step();
      o = outs(0);
      if (c <= 120) begin
        if ((o[3] !== (b2b_seq[(c-1)/CPB] == "1")) && (bad_cyc < 0)) bad_cyc = c;
        if (o[2] !== 1'b1) busy_ok = 1'b0;
      end
      if (o[1] === 1'b1) begin
        if (n_pop < 3) pop_at[n_pop] = c;
        n_pop++;
        void'(fifo_q.pop_front());
      end
      if (o[0] === 1'b1) begin
        if (n_done < 3) done_at[n_done] = c;
        n_done++;
      end
      if (fifo_q.size() != 0) drive_in(0, 1'b1, fifo_q[0]);
      else                    drive_in(0, 1'b0, 8'h00);
    end
    check("b2b/tx_first_bad_cycle", bad_cyc, -1);
    check("b2b/busy_continuous", {31'd0, busy_ok}, 1);
    check("b2b/pop_count", n_pop, 3);
    check("b2b/pop0_cycle", pop_at[0], 1);
    check("b2b/pop1_cycle", pop_at[1], 41);
    check("b2b/pop2_cycle", pop_at[2], 81);
    check("b2b/done_count", n_done, 3);
    check("b2b/done0_cycle", done_at[0], 41);
    check("b2b/done1_cycle", done_at[1], 81);
    check("b2b/done2_cycle", done_at[2], 121);
    check("b2b/after_tx_busy", {30'd0, o[3:2]}, 2'b10);
    step();

    // Reset during DATA bit 3 (cycles 17..20 of the frame), then a fresh frame.
    drive_in(0, 1'b1, 8'hA5);
    step();
    drive_in(0, 1'b0, 8'h00);
    for (int c = 2; c <= 18; c++) step();
    o = outs(0);
    check("midreset/before_tx_busy", {30'd0, o[3:2]}, 2'b01);
    rst = 1'b0;
    step();
    o = outs(0);
    check("midreset/aborted_tx_busy_pop_done", {28'd0, o}, 4'b1000);
    rst = 1'b1;
    run_frame(0, 8'h3C, "0001111001", "after_midreset");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
